// File: rtl/mrv32_muldiv.sv
// ---------------------------------------------------------------------------
// mrv32_muldiv
// Iterative RV32M multiply/divide unit for the execute stage. Multiplies use
// a shift-add loop (one multiplier bit per cycle, 64-bit accumulator);
// divides use a restoring loop (one quotient bit per cycle). Both run on the
// unsigned magnitudes and fix the sign on the last iteration. Divide-by-zero
// and signed overflow are resolved in IDLE and go straight to DONE.
//
// Optional feature macro: MRV32_MULDIV_FAST_MUL_EN
//   defined   -> multiplies use a single-cycle 33x33 signed product in IDLE
//   undefined -> multiplies use the 32-cycle shift-add loop
//
// Ports
//   i_clk     : clock, rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_start   : operation request, sampled only in IDLE
//   i_funct3  : RV32M selector (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU)
//   i_op1     : rs1 (multiplicand / dividend)
//   i_op2     : rs2 (multiplier / divisor)
//   i_flush   : synchronous kill of the current operation
//   o_busy    : high while not IDLE
//   o_done    : one-cycle completion pulse
//   o_result  : result, valid with o_done and held until the next o_done
// ---------------------------------------------------------------------------
module mrv32_muldiv (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic        i_start,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_op1,
   input  logic [31:0] i_op2,
   input  logic        i_flush,
   output logic        o_busy,
   output logic        o_done,
   output logic [31:0] o_result
);

   typedef enum logic [1:0] {S_IDLE, S_CALC, S_DONE} state_t;

   state_t      r_state;
   state_t      w_stateNext;
   logic [4:0]  r_count;
   logic [2:0]  r_funct3;
   logic        r_neg;
   logic [63:0] r_acc;
   logic [63:0] r_opa;
   logic [31:0] r_opb;
   logic [31:0] r_pending;
   logic [31:0] r_result;

   logic        w_isDiv;
   logic        w_op1Signed;
   logic        w_op2Signed;
   logic        w_neg1;
   logic        w_neg2;
   logic [31:0] w_mag1;
   logic [31:0] w_mag2;
   logic        w_resNeg;
   logic        w_divZero;
   logic        w_overflow;
   logic        w_special;
   logic [31:0] w_specialResult;
   logic        w_accept;

   logic [63:0] w_mulAcc;
   logic [32:0] w_divShift;
   logic        w_divGe;
   logic [31:0] w_divSub;
   logic [31:0] w_divRem;
   logic [63:0] w_accNext;
   logic [63:0] w_prodFix;
   logic [31:0] w_quoFix;
   logic [31:0] w_remFix;
   logic [31:0] w_calcResult;

   // Operand decode. MULHSU treats only op1 as signed; MUL's low word is the
   // same either way, so it runs unsigned. 0x80000000 negates to itself,
   // which read as unsigned is exactly 2^31.
   assign w_isDiv     = i_funct3[2];
   assign w_op1Signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b010) ||
                        (i_funct3 == 3'b100) || (i_funct3 == 3'b110);
   assign w_op2Signed = (i_funct3 == 3'b001) || (i_funct3 == 3'b100) ||
                        (i_funct3 == 3'b110);
   assign w_neg1      = w_op1Signed & i_op1[31];
   assign w_neg2      = w_op2Signed & i_op2[31];
   assign w_mag1      = w_neg1 ? (~i_op1 + 32'd1) : i_op1;
   assign w_mag2      = w_neg2 ? (~i_op2 + 32'd1) : i_op2;
   // The remainder follows the dividend's sign; everything else uses the XOR.
   assign w_resNeg    = (i_funct3 == 3'b110) ? w_neg1 : (w_neg1 ^ w_neg2);
   assign w_divZero   = w_isDiv && (i_op2 == 32'd0);
   assign w_overflow  = w_isDiv && !i_funct3[0] &&
                        (i_op1 == 32'h8000_0000) && (i_op2 == 32'hFFFF_FFFF);
   assign w_accept    = i_start && !i_flush;

`ifdef MRV32_MULDIV_FAST_MUL_EN
   // 33x33 signed product: each operand gets a sign bit chosen by funct3,
   // extended to 64 bits so only the bits we keep are ever computed.
   logic signed [63:0] w_fa;
   logic signed [63:0] w_fb;
   logic        [63:0] w_fastProd;
   assign w_fa       = {{32{w_neg1}}, i_op1};
   assign w_fb       = {{32{w_neg2}}, i_op2};
   assign w_fastProd = w_fa * w_fb;
   assign w_special  = w_divZero || w_overflow || !w_isDiv;
`else
   assign w_special  = w_divZero || w_overflow;
`endif

   // Results that never need the iterative loop.
   always_comb begin
      w_specialResult = 32'd0;
      if (w_divZero)
         w_specialResult = i_funct3[1] ? i_op1 : 32'hFFFF_FFFF;
      else if (w_overflow)
         w_specialResult = i_funct3[1] ? 32'd0 : 32'h8000_0000;
`ifdef MRV32_MULDIV_FAST_MUL_EN
      else if (!w_isDiv)
         w_specialResult = (i_funct3[1:0] == 2'b00) ? w_fastProd[31:0] : w_fastProd[63:32];
`endif
   end

   // One iteration step. For divide, r_acc holds {remainder, dividend/quotient}
   // and the next dividend bit shifts into the 33-bit trial remainder. Since the
   // remainder is always below the divisor, the difference fits in 32 bits.
   assign w_mulAcc   = r_acc + (r_opb[0] ? r_opa : 64'd0);
   assign w_divShift = {r_acc[63:32], r_acc[31]};
   assign w_divGe    = w_divShift >= {1'b0, r_opb};
   assign w_divSub   = w_divShift[31:0] - r_opb;
   assign w_divRem   = w_divGe ? w_divSub : w_divShift[31:0];
   assign w_accNext  = r_funct3[2] ? {w_divRem, r_acc[30:0], w_divGe} : w_mulAcc;

   // Sign fix-up applied to the final step's value.
   assign w_prodFix  = r_neg ? (~w_accNext + 64'd1) : w_accNext;
   assign w_quoFix   = r_neg ? (~w_accNext[31:0] + 32'd1) : w_accNext[31:0];
   assign w_remFix   = r_neg ? (~w_accNext[63:32] + 32'd1) : w_accNext[63:32];

   always_comb begin
      w_calcResult = 32'd0;
      if (r_funct3[2])
         w_calcResult = r_funct3[1] ? w_remFix : w_quoFix;
      else
         w_calcResult = (r_funct3[1:0] == 2'b00) ? w_prodFix[31:0] : w_prodFix[63:32];
   end

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n)
         r_state <= S_IDLE;
      else
         r_state <= w_stateNext;
   end

   // Next state and handshake outputs. done is suppressed when flush kills
   // the operation in its DONE cycle.
   always_comb begin
      w_stateNext = r_state;
      o_busy      = (r_state != S_IDLE);
      o_done      = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            if (w_accept)
               w_stateNext = w_special ? S_DONE : S_CALC;
         end
         S_CALC: begin
            if (i_flush)
               w_stateNext = S_IDLE;
            else if (r_count == 5'd31)
               w_stateNext = S_DONE;
         end
         S_DONE: begin
            w_stateNext = S_IDLE;
            o_done      = !i_flush;
         end
         default: w_stateNext = S_IDLE;
      endcase
   end

   // Datapath. The answer is staged in r_pending and only committed to
   // r_result in an unflushed DONE cycle, so a flush leaves the visible
   // result untouched.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_count   <= 5'd0;
         r_funct3  <= 3'd0;
         r_neg     <= 1'b0;
         r_acc     <= 64'd0;
         r_opa     <= 64'd0;
         r_opb     <= 32'd0;
         r_pending <= 32'd0;
         r_result  <= 32'd0;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (w_accept) begin
                  r_funct3 <= i_funct3;
                  r_neg    <= w_resNeg;
                  r_count  <= 5'd0;
                  r_opa    <= {32'd0, w_mag1};
                  r_opb    <= w_mag2;
                  r_acc    <= w_isDiv ? {32'd0, w_mag1} : 64'd0;
                  if (w_special)
                     r_pending <= w_specialResult;
               end
            end
            S_CALC: begin
               if (!i_flush) begin
                  r_acc   <= w_accNext;
                  r_opa   <= r_opa << 1;
                  r_opb   <= r_funct3[2] ? r_opb : (r_opb >> 1);
                  r_count <= r_count + 5'd1;
                  if (r_count == 5'd31)
                     r_pending <= w_calcResult;
               end
            end
            S_DONE: begin
               if (!i_flush)
                  r_result <= r_pending;
            end
            default: ;
         endcase
      end
   end

   assign o_result = ((r_state == S_DONE) && !i_flush) ? r_pending : r_result;

endmodule

// File: doc/mrv32_muldiv.md
# mrv32_muldiv

Iterative RV32M multiply/divide unit that sits beside the single-cycle integer ALU in the execute stage. It accepts the same operand pair (`op1`, `op2`) with an M-extension `funct3` selector. It computes the full 64-bit product or the 32-bit quotient/remainder over multiple cycles and returns a registered 32-bit result with a one-cycle `done` pulse. The pipeline stalls on `busy` and can kill an in-flight operation with `flush`.

## Interface
- No parameters; datapath width fixed at 32 (RV32).
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: request; sampled only when the unit is idle.
- `funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `op1` input 32: rs1 value (multiplicand / dividend).
- `op2` input 32: rs2 value (multiplier / divisor).
- `flush` input 1: synchronous kill of the current operation.
- `busy` output 1: high while state ≠ IDLE.
- `done` output 1: one-cycle pulse; `result` is valid in the same cycle.
- `result` output 32: registered result; holds its value until the next `done`.

## Operation
- States:
  - IDLE: accepts `start`.
  - CALC: iterates; 5-bit counter runs 0..31.
  - DONE: pulses `done`, then returns to IDLE.
- IDLE + `start` + no special case: latch operands and op, go to CALC.
- IDLE + `start` + special case: go directly to DONE with the special result.
- Signed handling:
  - Take magnitudes of signed operands; compute unsigned.
  - Negate the 64-bit product if the signs differ. MULHSU treats only `op1` as signed.
  - Quotient sign = sign(op1) XOR sign(op2).
  - Remainder sign = sign(op1).
  - The magnitude of 0x80000000 is 2^31 and fits in 32 unsigned bits.
- Multiply: shift-add, one multiplier bit per CALC cycle, 64-bit accumulator.
  - MUL returns the low word; MULH/MULHSU/MULHU return the high word.
- Divide: restoring algorithm, one quotient bit per CALC cycle, 33-bit partial remainder.
- Special cases, resolved in IDLE without entering CALC:
  - Divide by zero (DIV/DIVU): quotient 0xFFFFFFFF.
  - Remainder by zero (REM/REMU): result = `op1`.
  - Signed overflow, `op1`=0x80000000 and `op2`=0xFFFFFFFF with DIV: 0x80000000. With REM: 0.
- CALC exit: after counter = 31, apply the sign fix-up, write `result`, go to DONE.
- DONE: `done`=1 for one cycle, then IDLE; `start` is ignored in DONE.
- `start` while `busy` is ignored; the pipeline must hold the request.
- `flush` in CALC or DONE: go to IDLE at the next edge, no `done` pulse, `result` unchanged.
- `flush` and `start` together in IDLE: flush wins; the request is dropped.

## Timing
- Reset (async assert, sync-safe release): state IDLE, counter 0, `busy` 0, `done` 0, `result` 0x00000000.
- `start` sampled at edge N:
  - Iterative path: `busy` high from N+1; CALC occupies cycles N+1..N+32; `done` and `result` valid in cycle N+33; `busy` low from N+34.
  - Special-case path: `done` in cycle N+1; `busy` high only in N+1.
- Next `start` is accepted in the first IDLE cycle, i.e. one cycle after `done`.
- Reset asserted mid-operation: immediate return to reset values; no `done`.

## Configuration
- Macro: `MRV32_MULDIV_FAST_MUL_EN`.
- When defined:
  - Multiplies use a single-cycle combinational 33×33 signed product computed in IDLE, go straight to DONE, and set `done` in N+1.
  - Divides are unchanged.
- When undefined: multiplies use the 32-cycle shift-add path described above.

## Test plan
- MUL, `op1`=7, `op2`=0xFFFFFFFD → `result`=0xFFFFFFEB. `done` exactly 33 cycles after `start` (1 cycle with `MRV32_MULDIV_FAST_MUL_EN`).
- High-word multiplies:
  - MULH 0x80000000×0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide, `op1`=0xFFFFFFF9 (−7), `op2`=2:
  - DIV → 0xFFFFFFFD (−3).
  - REM → 0xFFFFFFFF (−1).
  - DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Divide by zero, `op1`=5, `op2`=0:
  - DIVU → 0xFFFFFFFF; REMU → 5.
  - `done` 1 cycle after `start`; `busy` high for 1 cycle.
- Signed overflow, DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0; `done` in N+1.
- Flush and busy handling:
  - Assert `flush` in the 10th CALC cycle → `busy` low next cycle, no `done`, `result` keeps the prior value.
  - `start` pulsed during CALC is ignored.
  - `rst_n` low mid-CALC → `busy`/`done`/`result` return to 0 immediately.
